// File: rtl/complex_unit_scheduler_if.sv
// complex_unit_scheduler_if: request, unit and writeback bundle for the
// shared multiply/divide scheduler.
interface complex_unit_scheduler_if #(
  parameter int NREQ  = 2,
  parameter int TAG_W = 6
);
  localparam int SW = $clog2(NREQ);

  logic                  flush_i;
  logic [NREQ-1:0]       req_valid_i;
  logic [NREQ-1:0]       req_ready_o;
  logic [NREQ*3-1:0]     req_opcode_i;
  logic [NREQ*32-1:0]    req_op1_i;
  logic [NREQ*32-1:0]    req_op2_i;
  logic [NREQ*TAG_W-1:0] req_tag_i;

  logic                  cu_valid_o;
  logic [2:0]            cu_opcode_o;
  logic [31:0]           cu_op1_o;
  logic [31:0]           cu_op2_o;
  logic                  cu_flush_o;
  logic                  cu_busy_i;
  logic [31:0]           cu_result_i;
  logic                  cu_wb_valid_i;

  logic                  wb_valid_o;
  logic                  wb_ready_i;
  logic [31:0]           wb_result_o;
  logic [TAG_W-1:0]      wb_tag_o;
  logic [SW-1:0]         wb_src_o;
  logic [31:0]           busy_cycles_o;

  modport slave (
    input  flush_i, req_valid_i, req_opcode_i,
    input  req_op1_i, req_op2_i, req_tag_i,
    input  cu_busy_i, cu_result_i, cu_wb_valid_i,
    input  wb_ready_i,
    output req_ready_o, cu_valid_o, cu_opcode_o,
    output cu_op1_o, cu_op2_o, cu_flush_o,
    output wb_valid_o, wb_result_o, wb_tag_o,
    output wb_src_o, busy_cycles_o
  );

  modport master (
    output flush_i, req_valid_i, req_opcode_i,
    output req_op1_i, req_op2_i, req_tag_i,
    output cu_busy_i, cu_result_i, cu_wb_valid_i,
    output wb_ready_i,
    input  req_ready_o, cu_valid_o, cu_opcode_o,
    input  cu_op1_o, cu_op2_o, cu_flush_o,
    input  wb_valid_o, wb_result_o, wb_tag_o,
    input  wb_src_o, busy_cycles_o
  );
endinterface

// File: rtl/complex_unit_scheduler.sv
// complex_unit_scheduler: round-robin sharing of one mul/div unit.
// Optional busy-cycle counter: COMPLEX_UNIT_SCHED_PERF_EN.
module complex_unit_scheduler #(
  parameter int NREQ  = 2,
  parameter int TAG_W = 6
) (
  input  logic clk_i,
  input  logic rst_ni,
  complex_unit_scheduler_if.slave bus
);
  localparam int SW = $clog2(NREQ);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, HOLD, DRAIN
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [SW-1:0]    r_ptr;
  logic [SW-1:0]    r_src;
  logic [2:0]       r_opc;
  logic [31:0]      r_op1;
  logic [31:0]      r_op2;
  logic [31:0]      r_res;
  logic [TAG_W-1:0] r_tag;

  int               w_dist;
  int               w_best;
  logic [SW-1:0]    w_gnt_idx;
  logic [2:0]       w_opc;
  logic [31:0]      w_op1;
  logic [31:0]      w_op2;
  logic [TAG_W-1:0] w_tag;
  logic             w_take;

  // closest valid port at or after the pointer wins
  always_comb begin
    w_dist    = 0;
    w_best    = NREQ;
    w_gnt_idx = '0;
    w_opc     = '0;
    w_op1     = '0;
    w_op2     = '0;
    w_tag     = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_dist = (i + NREQ - int'(r_ptr)) % NREQ;
      if (bus.req_valid_i[i] && w_dist < w_best) begin
        w_best    = w_dist;
        w_gnt_idx = SW'(i);
        w_opc     = bus.req_opcode_i[i*3 +: 3];
        w_op1     = bus.req_op1_i[i*32 +: 32];
        w_op2     = bus.req_op2_i[i*32 +: 32];
        w_tag     = bus.req_tag_i[i*TAG_W +: TAG_W];
      end
    end
  end

  // the unit has no reset, so a grant also waits for it to go idle
  assign w_take = rst_ni && (r_state == IDLE) &&
                  (w_best < NREQ) && !bus.flush_i &&
                  !bus.cu_busy_i;

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:  if (w_take) w_state_nx = ISSUE;
      ISSUE: w_state_nx = bus.flush_i ? IDLE : WAIT;
      WAIT: begin
        if (bus.flush_i)
          w_state_nx = bus.cu_wb_valid_i ? IDLE : DRAIN;
        else if (bus.cu_wb_valid_i)
          w_state_nx = HOLD;
      end
      HOLD: begin
        if (bus.flush_i || bus.wb_ready_i)
          w_state_nx = IDLE;
      end
      DRAIN: begin
        if (!bus.cu_busy_i || bus.cu_wb_valid_i)
          w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_src   <= '0;
      r_opc   <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_tag   <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_take) begin
        r_src <= w_gnt_idx;
        r_opc <= w_opc;
        r_op1 <= w_op1;
        r_op2 <= w_op2;
        r_tag <= w_tag;
        r_ptr <= (w_gnt_idx == SW'(NREQ - 1)) ?
                 '0 : w_gnt_idx + SW'(1);
      end
      if (r_state == WAIT && bus.cu_wb_valid_i &&
          !bus.flush_i)
        r_res <= bus.cu_result_i;
    end
  end

  assign bus.req_ready_o = w_take ?
    ({{(NREQ-1){1'b0}}, 1'b1} << w_gnt_idx) : '0;
  assign bus.cu_valid_o  = (r_state == ISSUE) && !bus.flush_i;
  assign bus.cu_opcode_o = r_opc;
  assign bus.cu_op1_o    = r_op1;
  assign bus.cu_op2_o    = r_op2;
  assign bus.cu_flush_o  = bus.flush_i;
  assign bus.wb_valid_o  = (r_state == HOLD);
  assign bus.wb_result_o = r_res;
  assign bus.wb_tag_o    = r_tag;
  assign bus.wb_src_o    = r_src;

`ifdef COMPLEX_UNIT_SCHED_PERF_EN
  logic [31:0] r_busy_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_busy_cnt <= '0;
    else if (r_state != IDLE && r_busy_cnt != '1)
      r_busy_cnt <= r_busy_cnt + 32'd1;
  end

  assign bus.busy_cycles_o = r_busy_cnt;
`else
  assign bus.busy_cycles_o = '0;
`endif
endmodule

// File: tb/tb_complex_unit_scheduler.sv
// tb_complex_unit_scheduler: directed scoreboard bench with a
// behavioural mul/div unit that samples its opcode at completion.
module tb_complex_unit_scheduler;
  localparam int NREQ  = 2;
  localparam int TAG_W = 6;
  localparam int SW    = $clog2(NREQ);

  typedef struct packed {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic [SW-1:0]    src;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int   compared   = 0;
  int   mismatched = 0;
  exp_t sb[$];
  int   grants[$];

  logic [31:0]      pexp [NREQ];
  logic [TAG_W-1:0] ptag [NREQ];
  logic [NREQ-1:0]  oneshot = '0;

  int          u_lat      = 3;
  int          u_cnt      = 0;
  logic        u_busy     = 1'b0;
  logic        u_wbv      = 1'b0;
  logic [31:0] u_res      = '0;
  logic        u_rst_seen = 1'b0;
  logic [2:0]  s_opc      = '0;
  logic [31:0] s_a        = '0;
  logic [31:0] s_b        = '0;
  int          hold_bad   = 0;
  int          gate_viol  = 0;
  int          n_cuv      = 0;

  complex_unit_scheduler_if #(.NREQ(NREQ), .TAG_W(TAG_W)) bus ();

  complex_unit_scheduler #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] calc(input logic [2:0] o,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    if (!o[2]) return o[1] ? p[63:32] : p[31:0];
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    return o[1] ? a % b : a / b;
  endfunction

  // unit model: no reset, result computed from the held operands
  always @(posedge clk) begin
    u_wbv <= 1'b0;
    if (!rst_n) u_rst_seen <= 1'b1;
    if (bus.cu_valid_o) begin
      u_busy     <= 1'b1;
      u_cnt      <= u_lat;
      s_opc      <= bus.cu_opcode_o;
      s_a        <= bus.cu_op1_o;
      s_b        <= bus.cu_op2_o;
      u_rst_seen <= 1'b0;
    end else if (u_busy) begin
      if (u_cnt == 1) begin
        u_busy <= 1'b0;
        u_wbv  <= 1'b1;
        u_res  <= calc(bus.cu_opcode_o, bus.cu_op1_o, bus.cu_op2_o);
        if (!u_rst_seen && rst_n &&
            {bus.cu_opcode_o, bus.cu_op1_o, bus.cu_op2_o} !=
            {s_opc, s_a, s_b})
          hold_bad <= hold_bad + 1;
      end else begin
        u_cnt <= u_cnt - 1;
      end
    end
  end

  assign bus.cu_busy_i     = u_busy;
  assign bus.cu_wb_valid_i = u_wbv;
  assign bus.cu_result_i   = u_res;

  always @(posedge clk) begin
    if (bus.cu_valid_o) n_cuv <= n_cuv + 1;
    if (bus.req_ready_o != '0 && bus.cu_busy_i)
      gate_viol <= gate_viol + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] t,
                          input logic [31:0] e, input logic os);
    bus.req_opcode_i[p*3 +: 3]         = o;
    bus.req_op1_i[p*32 +: 32]          = a;
    bus.req_op2_i[p*32 +: 32]          = b;
    bus.req_tag_i[p*TAG_W +: TAG_W]    = t;
    ptag[p]                            = t;
    pexp[p]                            = e;
    oneshot[p]                         = os;
    bus.req_valid_i[p]                 = 1'b1;
  endtask

  task automatic pop_chk();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    chk("wb_result", 64'(bus.wb_result_o), 64'(e.res));
    chk("wb_tag", 64'(bus.wb_tag_o), 64'(e.tag));
    chk("wb_src", 64'(bus.wb_src_o), 64'(e.src));
  endtask

  // call right after a falling edge; returns at a falling edge
  task automatic run(input int nres, input int budget);
    int              got  = 0;
    int              cyc  = 0;
    logic [NREQ-1:0] pend = '0;
    logic            pcw  = 1'b0;
    logic            pwbv = 1'b0;
    while (got < nres && cyc < budget) begin
      bus.req_valid_i = bus.req_valid_i & ~pend;
      pend = '0;
      #1;
      if (bus.wb_valid_o && !pwbv)
        chk("wb_latency", 64'(pcw), 64'd1);
      if (bus.wb_valid_o && bus.wb_ready_i) begin
        pop_chk();
        got++;
      end
      for (int p = 0; p < NREQ; p++) begin
        if (bus.req_ready_o[p] && bus.req_valid_i[p]) begin
          sb.push_back({pexp[p], ptag[p], SW'(p)});
          grants.push_back(p);
          if (oneshot[p]) pend[p] = 1'b1;
        end
      end
      pcw  = bus.cu_wb_valid_i;
      pwbv = bus.wb_valid_o;
      @(negedge clk);
      cyc++;
    end
    chk("run_done", 64'(got), 64'(nres));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    int          cuv0;
    int          gv0;
    int          bad;
    int          cyc;
    logic [63:0] snap;

    bus.flush_i      = 1'b0;
    bus.req_valid_i  = '0;
    bus.req_opcode_i = '0;
    bus.req_op1_i    = '0;
    bus.req_op2_i    = '0;
    bus.req_tag_i    = '0;
    bus.wb_ready_i   = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_wb_valid", 64'(bus.wb_valid_o), 64'd0);
    chk("rst_cu_valid", 64'(bus.cu_valid_o), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
    chk("rst_wb_result", 64'(bus.wb_result_o), 64'd0);
    chk("rst_busy_cnt", 64'(bus.busy_cycles_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // round robin with both ports requesting every cycle
    grants.delete();
    u_lat = 2;
    set_port(0, 3'b000, 32'd3, 32'd5, 6'd10, 32'd15, 1'b0);
    set_port(1, 3'b000, 32'd9, 32'd9, 6'd11, 32'd81, 1'b0);
    run(4, 200);
    bus.req_valid_i = '0;
    chk("rr_count", 64'(grants.size()), 64'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      chk("rr_order", 64'(grants[i]), 64'(i % 2));

    // single multiply, latency and pulse width
    @(negedge clk);
    base  = bus.busy_cycles_o;
    cuv0  = n_cuv;
    u_lat = 3;
    set_port(0, 3'b000, 32'd7, 32'd6, 6'd5, 32'd42, 1'b1);
    run(1, 50);
    repeat (2) @(negedge clk);
    chk("cu_valid_pulses", 64'(n_cuv - cuv0), 64'd1);
`ifdef COMPLEX_UNIT_SCHED_PERF_EN
    chk("perf_delta", 64'(bus.busy_cycles_o - base),
        64'(u_lat + 3));
`endif

    // divide and remainder by zero, plain divide
    u_lat = 6;
    set_port(0, 3'b100, 32'd100, 32'd0, 6'd7, 32'hFFFF_FFFF, 1'b1);
    run(1, 60);
    set_port(1, 3'b110, 32'd100, 32'd0, 6'd8, 32'd100, 1'b1);
    run(1, 60);
    set_port(0, 3'b100, 32'd100, 32'd7, 6'd9, 32'd14, 1'b1);
    run(1, 60);
    chk("operands_held", 64'(hold_bad), 64'd0);

    // writeback back-pressure
    u_lat = 3;
    bus.wb_ready_i = 1'b0;
    set_port(0, 3'b000, 32'd12, 32'd12, 6'd20, 32'd144, 1'b1);
    #1;
    chk("stall_grant", 64'(bus.req_ready_o), 64'd1);
    sb.push_back({32'd144, 6'd20, SW'(0)});
    @(negedge clk);
    bus.req_valid_i[0] = 1'b0;
    cyc = 0;
    while (!bus.wb_valid_o && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("stall_wb_seen", 64'(bus.wb_valid_o), 64'd1);
    snap = 64'({bus.wb_result_o, bus.wb_tag_o, bus.wb_src_o});
    set_port(1, 3'b000, 32'd2, 32'd2, 6'd21, 32'd4, 1'b1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (!bus.wb_valid_o || bus.req_ready_o != '0 ||
          64'({bus.wb_result_o, bus.wb_tag_o, bus.wb_src_o}) != snap)
        bad++;
    end
    chk("stall_stable", 64'(bad), 64'd0);
    bus.wb_ready_i = 1'b1;
    #1;
    pop_chk();
    @(negedge clk);
    #1;
    chk("stall_release", 64'(bus.wb_valid_o), 64'd0);
    chk("stall_next_grant", 64'(bus.req_ready_o), 64'd2);
    run(1, 60);

    // flush while the unit is working
    u_lat = 8;
    set_port(0, 3'b100, 32'd100, 32'd7, 6'd30, 32'd14, 1'b1);
    #1;
    chk("flush_grant", 64'(bus.req_ready_o), 64'd1);
    @(negedge clk);
    bus.req_valid_i[0] = 1'b0;
    repeat (3) @(negedge clk);
    bus.flush_i = 1'b1;
    #1;
    chk("flush_mirror", 64'(bus.cu_flush_o), 64'd1);
    @(negedge clk);
    bus.flush_i = 1'b0;
    gv0 = gate_viol;
    u_lat = 3;
    set_port(1, 3'b000, 32'd4, 32'd4, 6'd31, 32'd16, 1'b1);
    #1;
    chk("drain_no_grant", 64'(bus.req_ready_o), 64'd0);
    chk("drain_no_wb", 64'(bus.wb_valid_o), 64'd0);
    run(1, 80);
    chk("drain_gate", 64'(gate_viol - gv0), 64'd0);

    // reset in the middle of an operation
    u_lat = 8;
    set_port(0, 3'b000, 32'd5, 32'd5, 6'd40, 32'd25, 1'b1);
    @(negedge clk);
    bus.req_valid_i[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cu_op1", 64'(bus.cu_op1_o), 64'd0);
    chk("mid_rst_cu_opc", 64'(bus.cu_opcode_o), 64'd0);
    chk("mid_rst_wb_res", 64'(bus.wb_result_o), 64'd0);
    chk("mid_rst_wb_tag", 64'(bus.wb_tag_o), 64'd0);
    chk("mid_rst_wb_src", 64'(bus.wb_src_o), 64'd0);
    chk("mid_rst_wb_valid", 64'(bus.wb_valid_o), 64'd0);
    chk("mid_rst_busy_cnt", 64'(bus.busy_cycles_o), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    gv0 = gate_viol;
    u_lat = 3;
    set_port(1, 3'b000, 32'd6, 32'd7, 6'd41, 32'd42, 1'b1);
    #1;
    chk("post_rst_wait", 64'(bus.req_ready_o), 64'd0);
    run(1, 80);
    chk("post_rst_gate", 64'(gate_viol - gv0), 64'd0);
    chk("operands_held_end", 64'(hold_bad), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
